// File: rtl/cla_seq_arb16_pkg.sv
// Shared constants for the time-shared CLA adder: slice width and FSM encoding.
package cla_seq_arb16_pkg;

  localparam int unsigned SLICE_W = 4;
  localparam int unsigned STATE_W = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/cla4_core.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_core
  import cla_seq_arb16_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Every carry is expanded directly from generate/propagate and cin.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign sum  = w_p ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];

endmodule

// File: rtl/cla_seq_arb16.sv
// Two-requester round-robin adder: one CLA slice reused nibble by nibble,
// LSB first, with a held response until the consumer takes it.
module cla_seq_arb16
  import cla_seq_arb16_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [SLICE_W*NIBBLES-1:0]   req0_a,
  input  logic [SLICE_W*NIBBLES-1:0]   req0_b,
  input  logic                         req0_cin,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [SLICE_W*NIBBLES-1:0]   req1_a,
  input  logic [SLICE_W*NIBBLES-1:0]   req1_b,
  input  logic                         req1_cin,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_id,
  output logic [SLICE_W*NIBBLES-1:0]   rsp_sum,
  output logic                         rsp_cout
);

  localparam int unsigned W    = SLICE_W * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_acc;
  logic [W-1:0]       r_rsp_sum;
  logic               r_carry;
  logic               r_id;
  logic               r_last_grant;
  logic               r_rsp_cout;
  logic               r_rsp_id;
  logic [IDXW-1:0]    r_idx;

  logic               w_any_req;
  logic               w_accept;
  logic               w_gnt_id;
  logic               w_last_nib;
  logic [W-1:0]       w_a_in;
  logic [W-1:0]       w_b_in;
  logic               w_cin_in;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic [W-1:0]       w_result;

  // Round-robin: on contention the requester not granted last time wins.
  assign w_any_req  = req0_valid | req1_valid;
  assign w_gnt_id   = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;
  assign w_accept   = (r_state == ST_IDLE) && w_any_req;
  assign req0_ready = w_accept & ~w_gnt_id & rst_n;
  assign req1_ready = w_accept &  w_gnt_id & rst_n;

  assign w_a_in   = w_gnt_id ? req1_a   : req0_a;
  assign w_b_in   = w_gnt_id ? req1_b   : req0_b;
  assign w_cin_in = w_gnt_id ? req1_cin : req0_cin;

  assign w_a_nib    = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_nib    = r_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last_nib = (r_idx == IDXW'(NIBBLES - 1));

  cla4_core u_cla4_core (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Accumulator with the current nibble merged in, so the last step can publish it.
  always_comb begin
    w_result = r_acc;
    w_result[r_idx*SLICE_W +: SLICE_W] = w_sum;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_any_req)  w_state_nxt = ST_CALC;
      ST_CALC: if (w_last_nib) w_state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready)  w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_carry      <= 1'b0;
      r_id         <= 1'b0;
      r_idx        <= '0;
      r_last_grant <= 1'b1;
      r_rsp_sum    <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_id     <= 1'b0;
    end else if (w_accept) begin
      r_a          <= w_a_in;
      r_b          <= w_b_in;
      r_carry      <= w_cin_in;
      r_id         <= w_gnt_id;
      r_last_grant <= w_gnt_id;
      r_idx        <= '0;
    end else if (r_state == ST_CALC) begin
      r_acc   <= w_result;
      r_carry <= w_cout;
      r_idx   <= r_idx + IDXW'(1);
      if (w_last_nib) begin
        r_rsp_sum  <= w_result;
        r_rsp_cout <= w_cout;
        r_rsp_id   <= r_id;
      end
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_sum   = r_rsp_sum;
  assign rsp_cout  = r_rsp_cout;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_cla_seq_arb16.sv
// Randomised self-checking bench for cla_seq_arb16 against an arithmetic reference.
module tb_cla_seq_arb16;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_cout;
  logic [15:0] rsp_sum;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: round-robin pointer, reset value 1.
  logic m_last = 1'b1;

  // Observations of the most recent transaction.
  logic        o_gnt, o_id, o_cout;
  logic [15:0] o_sum;
  int          o_wait, o_lat;
  bit          o_both, o_busy, o_timeout, o_stable;

  cla_seq_arb16 #(.NIBBLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cin   (req0_cin),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cin   (req1_cin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic model_grant(input bit v0, input bit v1);
    logic g;
    g = (v0 && v1) ? ~m_last : v1;
    m_last = g;
    return g;
  endfunction

  function automatic logic [16:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin);
    return 17'(a) + 17'(b) + 17'(cin);
  endfunction

  // Drive one operation to completion; records observations, compares nothing.
  task automatic run_op(input bit v0, input bit v1,
                        input logic [15:0] a0, input logic [15:0] b0, input logic c0,
                        input logic [15:0] a1, input logic [15:0] b1, input logic c1,
                        input int stall, input bit keep);
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_cin = c0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_cin = c1;
    #1;
    o_wait = 0; o_both = 0; o_busy = 0; o_timeout = 0; o_stable = 1; o_lat = 0;
    while (!(req0_ready || req1_ready) && o_wait < 20) begin
      @(negedge clk); #1; o_wait++;
    end
    if (!(req0_ready || req1_ready)) begin o_timeout = 1; return; end
    o_both = req0_ready && req1_ready;
    o_gnt  = req1_ready;
    do begin
      @(negedge clk);
      o_lat++;
      if (!keep && o_lat == 1) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'($urandom); req0_b = 16'($urandom); req0_cin = 1'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom); req1_cin = 1'($urandom);
      end
      #1;
      if (req0_ready || req1_ready) o_busy = 1;
    end while (!rsp_valid && o_lat < 20);
    if (!rsp_valid) begin o_timeout = 1; return; end
    o_sum = rsp_sum; o_cout = rsp_cout; o_id = rsp_id;
    repeat (stall) begin
      @(negedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_sum !== o_sum || rsp_cout !== o_cout || rsp_id !== o_id)
        o_stable = 0;
      if (req0_ready || req1_ready) o_busy = 1;
    end
    rsp_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = '0; req0_b = '0; req0_cin = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got v=%b id=%b cout=%b r0=%b r1=%b, expected all 0",
               rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready);
    end
    n_checks++;
    if (rsp_sum !== 16'h0000) begin
      n_errors++; $display("FAIL reset_sum: got %h expected 0000", rsp_sum);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_last = 1'b1;
  endtask

  task automatic test_contention;
    logic exp_g;
    logic [16:0] e;
    for (int k = 0; k < 3; k++) begin
      run_op(1, 1, 16'h1111 * 16'(k + 1), 16'h0101, 1'b0, 16'h2222, 16'h0F0F * 16'(k), 1'b1, 0, 1);
      exp_g = model_grant(1, 1);
      e = exp_g ? model_add(16'h2222, 16'h0F0F * 16'(k), 1'b1)
                : model_add(16'h1111 * 16'(k + 1), 16'h0101, 1'b0);
      n_checks++;
      if (o_timeout || o_gnt !== exp_g || o_id !== exp_g) begin
        n_errors++;
        $display("FAIL contention_grant[%0d]: got gnt=%b id=%b to=%b expected %b", k, o_gnt, o_id, o_timeout, exp_g);
      end
      n_checks++;
      if (o_both || o_busy) begin
        n_errors++; $display("FAIL contention_ready[%0d]: both=%b busy=%b expected 0 0", k, o_both, o_busy);
      end
      n_checks++;
      if ({o_cout, o_sum} !== e) begin
        n_errors++; $display("FAIL contention_sum[%0d]: got %h expected %h", k, {o_cout, o_sum}, e);
      end
      n_checks++;
      if (k > 0 && o_wait !== 0) begin
        n_errors++; $display("FAIL throughput[%0d]: accept after %0d idle cycles expected 0", k, o_wait);
      end
    end
  endtask

  task automatic test_single;
    run_op(1, 0, 16'h0001, 16'h0000, 1'b0, 16'h0, 16'h0, 1'b0, 0, 0);
    void'(model_grant(1, 0));
    n_checks++;
    if (o_timeout || o_sum !== 16'h0001 || o_cout !== 1'b0 || o_id !== 1'b0) begin
      n_errors++; $display("FAIL single: got sum=%h cout=%b id=%b expected 0001 0 0", o_sum, o_cout, o_id);
    end
    n_checks++;
    if (o_lat !== 5) begin
      n_errors++; $display("FAIL single_latency: got %0d expected 5", o_lat);
    end
  endtask

  task automatic test_carry;
    run_op(0, 1, 16'h0, 16'h0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 0, 0);
    void'(model_grant(0, 1));
    n_checks++;
    if (o_timeout || o_sum !== 16'h0000 || o_cout !== 1'b1 || o_id !== 1'b1) begin
      n_errors++; $display("FAIL ripple: got sum=%h cout=%b id=%b expected 0000 1 1", o_sum, o_cout, o_id);
    end
    run_op(1, 0, 16'hA5A5, 16'h5A5A, 1'b0, 16'h0, 16'h0, 1'b0, 0, 0);
    void'(model_grant(1, 0));
    n_checks++;
    if (o_timeout || o_sum !== 16'hFFFF || o_cout !== 1'b0 || o_id !== 1'b0) begin
      n_errors++; $display("FAIL alternating: got sum=%h cout=%b id=%b expected FFFF 0 0", o_sum, o_cout, o_id);
    end
  endtask

  task automatic test_backpressure;
    logic exp_g;
    logic [16:0] e;
    run_op(1, 1, 16'h8421, 16'h7BDE, 1'b1, 16'h0F00, 16'hF100, 1'b0, 3, 1);
    exp_g = model_grant(1, 1);
    e = exp_g ? model_add(16'h0F00, 16'hF100, 1'b0) : model_add(16'h8421, 16'h7BDE, 1'b1);
    n_checks++;
    if (o_timeout || !o_stable) begin
      n_errors++; $display("FAIL bp_stable: stable=%b timeout=%b expected 1 0", o_stable, o_timeout);
    end
    n_checks++;
    if (o_busy || o_both) begin
      n_errors++; $display("FAIL bp_ready: busy=%b both=%b expected 0 0", o_busy, o_both);
    end
    n_checks++;
    if ({o_cout, o_sum} !== e || o_id !== exp_g) begin
      n_errors++; $display("FAIL bp_result: got %h id=%b expected %h id=%b", {o_cout, o_sum}, o_id, e, exp_g);
    end
  endtask

  task automatic test_reset_mid_calc;
    bit seen_valid;
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 16'hFFFF; req0_b = 16'h0001; req0_cin = 1'b1;
    req1_valid = 1'b0;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready} !== 5'b0 || rsp_sum !== 16'h0) begin
      n_errors++;
      $display("FAIL midcalc_reset: got v=%b id=%b cout=%b r0=%b r1=%b sum=%h expected zeros",
               rsp_valid, rsp_id, rsp_cout, req0_ready, req1_ready, rsp_sum);
    end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_last = 1'b1;
    seen_valid = 0;
    repeat (8) begin
      @(negedge clk); #1;
      if (rsp_valid) seen_valid = 1;
    end
    n_checks++;
    if (seen_valid) begin
      n_errors++; $display("FAIL midcalc_abort: rsp_valid=1 seen after aborted op, expected 0");
    end
    run_op(1, 0, 16'h1234, 16'h4321, 1'b0, 16'h0, 16'h0, 1'b0, 0, 0);
    void'(model_grant(1, 0));
    n_checks++;
    if (o_timeout || o_sum !== 16'h5555 || o_cout !== 1'b0 || o_id !== 1'b0 || o_lat !== 5) begin
      n_errors++;
      $display("FAIL midcalc_next: got sum=%h cout=%b id=%b lat=%0d expected 5555 0 0 5",
               o_sum, o_cout, o_id, o_lat);
    end
  endtask

  task automatic test_random;
    logic [15:0] a0, b0, a1, b1;
    logic        c0, c1, exp_g;
    logic [16:0] e;
    bit          v0, v1;
    int          sel;
    for (int k = 0; k < 24; k++) begin
      sel = int'($urandom_range(1, 3));
      v0 = sel[0]; v1 = sel[1];
      a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
      a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
      run_op(v0, v1, a0, b0, c0, a1, b1, c1, int'($urandom_range(0, 2)), 1'($urandom));
      exp_g = model_grant(v0, v1);
      e = exp_g ? model_add(a1, b1, c1) : model_add(a0, b0, c0);
      n_checks++;
      if (o_timeout || {o_cout, o_sum} !== e || o_id !== exp_g || o_gnt !== exp_g) begin
        n_errors++;
        $display("FAIL random[%0d]: got %h id=%b gnt=%b expected %h id=%b", k, {o_cout, o_sum}, o_id, o_gnt, e, exp_g);
      end
      n_checks++;
      if (o_lat !== 5 || o_wait !== 0 || !o_stable || o_busy || o_both) begin
        n_errors++;
        $display("FAIL random_timing[%0d]: lat=%0d wait=%0d stable=%b busy=%b both=%b expected 5 0 1 0 0",
                 k, o_lat, o_wait, o_stable, o_busy, o_both);
      end
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single();
    test_carry();
    test_backpressure();
    test_reset_mid_calc();
    test_random();
    @(negedge clk);
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
